// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
//   hz_state_e : memory-wait FSM encoding (RUN / MEM_WAIT)
//   hz_ctrl_t  : bundle of the five pipe-register hold/kill controls
package pipe_hazard_ctrl_pkg;

    localparam int REG_FILE_ADDR_LEN = 5;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic pc_freeze;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
    } hz_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
//   master : pipeline side, drives ID/EX/MEM hazard info and the SRAM handshake,
//            receives hold/kill controls, timeout flag and perf counters.
//   slave  : hazard controller side.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              forward_en;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_two_src;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_wb_en;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dest;
    logic              mem_wb_en;
    logic              branch_taken;
    logic              mem_req;
    logic              mem_ready;

    logic              pc_freeze;
    logic              if_id_freeze;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              pipe_freeze;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output forward_en, id_src1, id_src2, id_two_src, ex_dest, ex_wb_en,
               ex_mem_read, mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        input  pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze,
               mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  forward_en, id_src1, id_src2, id_two_src, ex_dest, ex_wb_en,
               ex_mem_read, mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
        output pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze,
               mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush perf counters.
//   clk, rst : clock, synchronous active-high reset (clears count)
//   inc      : add one this cycle (ignored once all-ones)
//   cnt      : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: produces PC/IF-ID freeze, IF-ID flush, ID-EX
// bubble and whole-pipe freeze for the 5-stage pipe, tracks slow SRAM accesses
// with a RUN/MEM_WAIT FSM (sticky timeout), and counts stall/flush cycles.
//   clk, rst : clock, synchronous active-high reset
//   hz       : hazard-control bus (slave side), see pipe_hazard_ctrl_if
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = REG_FILE_ADDR_LEN,
    parameter int CNT_W        = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);
    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_WAIT_MAX);

    // Register 0 is hardwired to zero, so writes to it never create a RAW hazard.
    function automatic logic raw_hit(
        input logic [REG_AW-1:0] dest,
        input logic              we,
        input logic [REG_AW-1:0] src1,
        input logic [REG_AW-1:0] src2,
        input logic              two_src
    );
        return we && (dest != '0) && ((dest == src1) || (two_src && (dest == src2)));
    endfunction

    hz_state_e         state_d, state_q;
    logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;
    logic              mem_timeout_d, mem_timeout_q;
    logic              mem_stall;
    logic              data_stall;
    logic              ex_hit;
    logic              mem_hit;
    hz_ctrl_t          ctrl;

    always_comb begin
        ex_hit  = raw_hit(hz.ex_dest,  hz.ex_wb_en,  hz.id_src1, hz.id_src2, hz.id_two_src);
        mem_hit = raw_hit(hz.mem_dest, hz.mem_wb_en, hz.id_src1, hz.id_src2, hz.id_two_src);
        // With forwarding only a load in EX cannot be bypassed in time.
        if (hz.forward_en) begin
            data_stall = ex_hit && hz.ex_mem_read;
        end else begin
            data_stall = ex_hit || mem_hit;
        end
    end

    // Mealy memory-wait FSM: the stall is asserted in the same cycle the
    // request misses, and released in the same cycle mem_ready arrives.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        mem_stall     = 1'b0;
        case (state_q)
            HZ_RUN: begin
                wait_cnt_d = '0;
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d   = HZ_MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = HZ_RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q != WAIT_LIMIT) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    // Timeout only flags; the access keeps waiting for ready.
                    if (wait_cnt_d == WAIT_LIMIT) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = HZ_RUN;
            end
        endcase
    end

    // Priority: memory stall > data hazard > taken branch. A branch under a
    // data stall is dropped here and re-resolved when ID re-issues.
    always_comb begin
        ctrl = '0;
        if (!rst) begin
            if (mem_stall) begin
                ctrl.pc_freeze    = 1'b1;
                ctrl.if_id_freeze = 1'b1;
                ctrl.pipe_freeze  = 1'b1;
            end else if (data_stall) begin
                ctrl.pc_freeze    = 1'b1;
                ctrl.if_id_freeze = 1'b1;
                ctrl.id_ex_bubble = 1'b1;
            end else if (hz.branch_taken) begin
                ctrl.if_id_flush  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HZ_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign hz.pc_freeze    = ctrl.pc_freeze;
    assign hz.if_id_freeze = ctrl.if_id_freeze;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_bubble = ctrl.id_ex_bubble;
    assign hz.pipe_freeze  = ctrl.pipe_freeze;
    assign hz.mem_timeout  = mem_timeout_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.pc_freeze),
        .cnt (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.if_id_flush),
        .cnt (hz.flush_cnt)
    );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pipe_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz_if ();

    pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.forward_en   = 1'b0;
        hz_if.id_src1      = '0;
        hz_if.id_src2      = '0;
        hz_if.id_two_src   = 1'b0;
        hz_if.ex_dest      = '0;
        hz_if.ex_wb_en     = 1'b0;
        hz_if.ex_mem_read  = 1'b0;
        hz_if.mem_dest     = '0;
        hz_if.mem_wb_en    = 1'b0;
        hz_if.branch_taken = 1'b0;
        hz_if.mem_req      = 1'b0;
        hz_if.mem_ready    = 1'b0;
    endtask

    task automatic set_load_use();
        hz_if.forward_en  = 1'b1;
        hz_if.ex_mem_read = 1'b1;
        hz_if.ex_wb_en    = 1'b1;
        hz_if.ex_dest     = 5'd3;
        hz_if.id_src1     = 5'd3;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed order: {pc_freeze, if_id_freeze, if_id_flush, id_ex_bubble, pipe_freeze}
    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {hz_if.pc_freeze, hz_if.if_id_freeze, hz_if.if_id_flush,
               hz_if.id_ex_bubble, hz_if.pipe_freeze};
        check(tag, {27'd0, obs}, {27'd0, exp});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clear_inputs();

        // Reset, with a pending miss to confirm outputs stay low under rst.
        rst = 1'b1;
        hz_if.mem_req = 1'b1;
        tick();
        tick();
        check_ctrl("rst_ctrl_zero", 5'b00000);
        check("rst_stall_cnt", hz_if.stall_cnt, 32'd0);
        check("rst_flush_cnt", hz_if.flush_cnt, 32'd0);
        check("rst_timeout", {31'd0, hz_if.mem_timeout}, 32'd0);
        rst = 1'b0;
        clear_inputs();
        #1;
        check_ctrl("idle_ctrl", 5'b00000);

        // Load-use with forwarding.
        set_load_use();
        #1;
        check_ctrl("fwd_load_use", 5'b11010);
        tick();
        check("fwd_load_use_cnt", hz_if.stall_cnt, 32'd1);
        hz_if.ex_dest = 5'd0;
        #1;
        check_ctrl("fwd_dest_r0", 5'b00000);
        hz_if.ex_dest     = 5'd3;
        hz_if.ex_mem_read = 1'b0;
        #1;
        check_ctrl("fwd_alu_no_stall", 5'b00000);
        tick();
        clear_inputs();

        // No forwarding: MEM-stage hit on src2.
        hz_if.mem_dest   = 5'd5;
        hz_if.mem_wb_en  = 1'b1;
        hz_if.id_two_src = 1'b1;
        hz_if.id_src2    = 5'd5;
        hz_if.id_src1    = 5'd7;
        #1;
        check_ctrl("nofwd_mem_src2", 5'b11010);
        tick();
        check("nofwd_cnt", hz_if.stall_cnt, 32'd2);
        hz_if.id_two_src = 1'b0;
        #1;
        check_ctrl("nofwd_one_src", 5'b00000);
        clear_inputs();
        hz_if.ex_dest  = 5'd4;
        hz_if.ex_wb_en = 1'b1;
        hz_if.id_src1  = 5'd4;
        #1;
        check_ctrl("nofwd_ex_alu", 5'b11010);
        tick();
        clear_inputs();

        // Taken branch alone, then with a concurrent load-use.
        hz_if.branch_taken = 1'b1;
        #1;
        check_ctrl("branch_flush", 5'b00100);
        tick();
        check("branch_flush_cnt", hz_if.flush_cnt, 32'd1);
        set_load_use();
        #1;
        check_ctrl("branch_vs_load_use", 5'b11010);
        tick();
        check("branch_vs_lu_flush", hz_if.flush_cnt, 32'd1);
        check("branch_vs_lu_stall", hz_if.stall_cnt, 32'd4);
        clear_inputs();

        // Clear counters before the memory tests.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst2_stall_cnt", hz_if.stall_cnt, 32'd0);

        // Single-cycle SRAM access: no stall.
        hz_if.mem_req   = 1'b1;
        hz_if.mem_ready = 1'b1;
        #1;
        check_ctrl("mem_fast", 5'b00000);
        tick();

        // Four-cycle miss, load-use present to show memory stall dominates.
        hz_if.mem_ready = 1'b0;
        set_load_use();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_ctrl($sformatf("mem_wait_%0d", i), 5'b11001);
            tick();
        end
        hz_if.ex_mem_read = 1'b0;
        hz_if.mem_ready   = 1'b1;
        #1;
        check_ctrl("mem_ready_release", 5'b00000);
        check("mem_wait_stall_cnt", hz_if.stall_cnt, 32'd4);
        tick();
        clear_inputs();
        #1;
        check_ctrl("mem_back_run", 5'b00000);
        check("mem_back_stall_cnt", hz_if.stall_cnt, 32'd4);

        // Long miss: timeout after 15 MEM_WAIT cycles, sticky.
        hz_if.mem_req = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        check("timeout_early", {31'd0, hz_if.mem_timeout}, 32'd0);
        tick();
        check("timeout_set", {31'd0, hz_if.mem_timeout}, 32'd1);
        hz_if.mem_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_ctrl("timeout_still_wait", 5'b11001);
        check("timeout_held", {31'd0, hz_if.mem_timeout}, 32'd1);
        hz_if.mem_ready = 1'b1;
        #1;
        check_ctrl("timeout_ready", 5'b00000);
        tick();
        hz_if.mem_ready = 1'b0;
        #1;
        check_ctrl("timeout_exit_run", 5'b00000);
        check("timeout_sticky", {31'd0, hz_if.mem_timeout}, 32'd1);
        check("timeout_stall_cnt", hz_if.stall_cnt, 32'd24);

        // Reset while in MEM_WAIT.
        hz_if.mem_req = 1'b1;
        tick();
        hz_if.mem_req = 1'b0;
        #1;
        check_ctrl("pre_rst_wait", 5'b11001);
        rst = 1'b1;
        #1;
        check_ctrl("rst_gates_wait", 5'b00000);
        tick();
        rst = 1'b0;
        #1;
        check_ctrl("post_rst_run", 5'b00000);
        check("post_rst_timeout", {31'd0, hz_if.mem_timeout}, 32'd0);
        check("post_rst_stall_cnt", hz_if.stall_cnt, 32'd0);
        tick();
        check_ctrl("post_rst_steady", 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
